// File: rtl/dac_lane_aligner.sv
// Sixteen-stream (8 I + 8 Q) lane aligner for the DAC front end.
// Per-stream FIFOs feed a single global pop so every channel sees the same sample index.
module dac_lane_aligner #(
  parameter int LANES     = 8,
  parameter int DW        = 16,
  parameter int DEPTH     = 16,
  parameter int PRIME_LVL = 8
) (
  input  logic                      clk_250m,
  input  logic                      reset,
  input  logic [LANES-1:0]          s_axis_inputI_tvalid,
  output logic [LANES-1:0]          s_axis_inputI_tready,
  input  logic [LANES-1:0][DW-1:0]  s_axis_inputI_tdata,
  input  logic [LANES-1:0]          s_axis_inputI_tlast,
  input  logic [LANES-1:0]          s_axis_inputQ_tvalid,
  output logic [LANES-1:0]          s_axis_inputQ_tready,
  input  logic [LANES-1:0][DW-1:0]  s_axis_inputQ_tdata,
  input  logic [LANES-1:0]          s_axis_inputQ_tlast,
  output logic [LANES-1:0]          m_axis_outputDAI_tvalid,
  output logic [LANES-1:0][DW-1:0]  m_axis_outputDAI_tdata,
  output logic [LANES-1:0]          m_axis_outputDAI_tlast,
  output logic [LANES-1:0]          m_axis_outputDAQ_tvalid,
  output logic [LANES-1:0][DW-1:0]  m_axis_outputDAQ_tdata,
  output logic [LANES-1:0]          m_axis_outputDAQ_tlast,
  output logic [15:0]               underrun_cnt,
  output logic                      align_err,
  output logic [1:0]                state
);

  localparam int NS = 2 * LANES;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] PRIME_CNT = CW'(PRIME_LVL);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRIME    = 2'd1,
    RUN      = 2'd2,
    UNDERRUN = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [NS-1:0]          in_valid;
  logic [NS-1:0]          in_last;
  logic [NS-1:0][DW-1:0]  in_data;
  logic [NS-1:0]          wr_en;
  logic [NS-1:0]          full;
  logic [NS-1:0]          nonempty;
  logic [NS-1:0]          primed;
  logic                   pop;

  logic [NS-1:0][AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [NS-1:0][AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [NS-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [DW:0]            mem_q [NS][DEPTH];
  logic [NS-1:0][DW:0]    head;
  logic [NS-1:0]          head_last;

  logic [15:0]            urun_q, urun_d;
  logic                   align_q, align_d;
  logic [NS-1:0]          out_valid_q, out_valid_d;
  logic [NS-1:0][DW-1:0]  out_data_q, out_data_d;
  logic [NS-1:0]          out_last_q, out_last_d;

  // Stream s < LANES is I lane s; stream s >= LANES is Q lane s-LANES.
  assign in_valid = {s_axis_inputQ_tvalid, s_axis_inputI_tvalid};
  assign in_last  = {s_axis_inputQ_tlast, s_axis_inputI_tlast};
  assign in_data  = {s_axis_inputQ_tdata, s_axis_inputI_tdata};

  always_comb begin
    full      = '0;
    nonempty  = '0;
    primed    = '0;
    wr_en     = '0;
    head      = '0;
    head_last = '0;
    for (int s = 0; s < NS; s++) begin
      full[s]      = (cnt_q[s] == FULL_CNT);
      nonempty[s]  = (cnt_q[s] != '0);
      primed[s]    = (cnt_q[s] >= PRIME_CNT);
      wr_en[s]     = in_valid[s] && !full[s];
      head[s]      = mem_q[s][rd_ptr_q[s]];
      head_last[s] = head[s][DW];
    end
  end

  assign s_axis_inputI_tready = ~full[LANES-1:0];
  assign s_axis_inputQ_tready = ~full[NS-1:LANES];

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    urun_d  = urun_q;
    unique case (state_q)
      IDLE: begin
        if (|nonempty) state_d = PRIME;
      end
      PRIME: begin
        if (&primed) state_d = RUN;
      end
      RUN: begin
        if (&nonempty) begin
          pop = 1'b1;
        end else begin
          state_d = UNDERRUN;
          if (urun_q != 16'hFFFF) urun_d = urun_q + 16'd1;
        end
      end
      UNDERRUN: begin
        if (&primed) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int s = 0; s < NS; s++) begin
      wr_ptr_d[s] = wr_ptr_q[s] + AW'(wr_en[s]);
      rd_ptr_d[s] = rd_ptr_q[s] + AW'(pop);
      cnt_d[s]    = cnt_q[s] + CW'(wr_en[s]) - CW'(pop);
    end
  end

  // A cycle without a pop drives zeros rather than repeating the last sample.
  always_comb begin
    out_valid_d = {NS{pop}};
    out_data_d  = '0;
    out_last_d  = '0;
    for (int s = 0; s < NS; s++) begin
      if (pop) begin
        out_data_d[s] = head[s][DW-1:0];
        out_last_d[s] = head_last[s];
      end
    end
    align_d = align_q | (pop && (|head_last) && !(&head_last));
  end

  always_ff @(posedge clk_250m) begin
    for (int s = 0; s < NS; s++) begin
      if (wr_en[s]) mem_q[s][wr_ptr_q[s]] <= {in_last[s], in_data[s]};
    end
  end

  always_ff @(posedge clk_250m) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      urun_q      <= '0;
      align_q     <= 1'b0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_last_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      urun_q      <= urun_d;
      align_q     <= align_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign m_axis_outputDAI_tvalid = out_valid_q[LANES-1:0];
  assign m_axis_outputDAQ_tvalid = out_valid_q[NS-1:LANES];
  assign m_axis_outputDAI_tdata  = out_data_q[LANES-1:0];
  assign m_axis_outputDAQ_tdata  = out_data_q[NS-1:LANES];
  assign m_axis_outputDAI_tlast  = out_last_q[LANES-1:0];
  assign m_axis_outputDAQ_tlast  = out_last_q[NS-1:LANES];
  assign underrun_cnt            = urun_q;
  assign align_err               = align_q;
  assign state                   = state_q;

endmodule

// File: tb/tb_dac_lane_aligner.sv
// Directed bench for dac_lane_aligner: priming, alignment, underrun,
// backpressure, tlast mismatch, reset mid-run and counter saturation.
module tb_dac_lane_aligner;
  localparam int L  = 8;
  localparam int NS = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #2 clk = ~clk;

  logic reset;
  logic [L-1:0] iv, ir, il, qv, qr, ql;
  logic [L-1:0][DW-1:0] id, qd;
  logic [L-1:0] oiv, oil, oqv, oql;
  logic [L-1:0][DW-1:0] oid, oqd;
  logic [15:0] ucnt;
  logic aerr;
  logic [1:0] st;

  int total = 0;
  int bad = 0;
  int n [NS];
  logic [NS-1:0] tl_en;

  dac_lane_aligner dut (
    .clk_250m(clk),
    .reset(reset),
    .s_axis_inputI_tvalid(iv),
    .s_axis_inputI_tready(ir),
    .s_axis_inputI_tdata(id),
    .s_axis_inputI_tlast(il),
    .s_axis_inputQ_tvalid(qv),
    .s_axis_inputQ_tready(qr),
    .s_axis_inputQ_tdata(qd),
    .s_axis_inputQ_tlast(ql),
    .m_axis_outputDAI_tvalid(oiv),
    .m_axis_outputDAI_tdata(oid),
    .m_axis_outputDAI_tlast(oil),
    .m_axis_outputDAQ_tvalid(oqv),
    .m_axis_outputDAQ_tdata(oqd),
    .m_axis_outputDAQ_tlast(oql),
    .underrun_cnt(ucnt),
    .align_err(aerr),
    .state(st)
  );

  // -1: idle beat (all zero); -2: malformed/misaligned; else common n.
  function automatic int beat_n();
    logic [NS-1:0] v, t;
    logic [NS-1:0][DW-1:0] d;
    v = {oqv, oiv};
    t = {oql, oil};
    d = {oqd, oid};
    if (v == '0) begin
      if (d == '0 && t == '0) return -1;
      return -2;
    end
    if (v != '1) return -2;
    for (int k = 0; k < NS; k++) begin
      if (d[k][15:8] != 8'(k)) return -2;
      if (d[k][7:0] != d[0][7:0]) return -2;
    end
    return int'(d[0][7:0]);
  endfunction

  task automatic cycle(input logic [NS-1:0] mask);
    logic [NS-1:0] acc;
    {qv, iv} = mask;
    for (int k = 0; k < L; k++) begin
      id[k] = 16'(k * 256 + n[k]);
      il[k] = tl_en[k] && (n[k] == 31);
    end
    for (int k = 0; k < L; k++) begin
      qd[k] = 16'((k + L) * 256 + n[k + L]);
      ql[k] = tl_en[k + L] && (n[k + L] == 31);
    end
    acc = mask & {qr, ir};
    @(negedge clk);
    for (int k = 0; k < NS; k++) if (acc[k]) n[k]++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    iv = '0; qv = '0; id = '0; qd = '0; il = '0; ql = '0;
    tl_en = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < NS; k++) n[k] = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (st !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", st); end
    total++;
    if (ucnt !== 16'd0) begin bad++; $display("FAIL reset_ucnt: got %0d want 0", ucnt); end
    total++;
    if (aerr !== 1'b0) begin bad++; $display("FAIL reset_aerr: got %0d want 0", aerr); end
    total++;
    if (beat_n() !== -1) begin bad++; $display("FAIL reset_out: got %0d want -1", beat_n()); end
    total++;
    if ({qr, ir} !== 16'hFFFF) begin bad++; $display("FAIL reset_ready: got %h want ffff", {qr, ir}); end
  endtask

  task automatic test_stream();
    int exp;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cycle('1);
      exp = (i >= 9) ? i - 9 : -1;
      total++;
      if (beat_n() !== exp) begin
        bad++; $display("FAIL stream_beat%0d: got %0d want %0d", i, beat_n(), exp);
      end
      if (i == 7) begin
        total++;
        if (st !== 2'd1) begin bad++; $display("FAIL stream_prime: got %0d want 1", st); end
      end
      if (i == 8) begin
        total++;
        if (st !== 2'd2) begin bad++; $display("FAIL stream_run: got %0d want 2", st); end
      end
    end
    total++;
    if (ucnt !== 16'd0) begin bad++; $display("FAIL stream_ucnt: got %0d want 0", ucnt); end
  endtask

  task automatic test_underrun();
    int exp;
    logic [NS-1:0] m;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      m = '1;
      if (i >= 20 && i <= 31) m[3] = 1'b0;
      cycle(m);
      if (i <= 8) exp = -1;
      else if (i <= 28) exp = i - 9;
      else if (i <= 40) exp = -1;
      else exp = i - 21;
      total++;
      if (beat_n() !== exp) begin
        bad++; $display("FAIL underrun_beat%0d: got %0d want %0d", i, beat_n(), exp);
      end
    end
    total++;
    if (ucnt !== 16'd1) begin bad++; $display("FAIL underrun_cnt: got %0d want 1", ucnt); end
  endtask

  task automatic test_full();
    int exp;
    do_reset();
    for (int i = 0; i < 20; i++) cycle(16'h7FFF);
    total++;
    if ({qr, ir} !== 16'h8000) begin bad++; $display("FAIL full_ready: got %h want 8000", {qr, ir}); end
    total++;
    if (n[0] !== 16 || n[14] !== 16) begin
      bad++; $display("FAIL full_accept: got %0d/%0d want 16/16", n[0], n[14]);
    end
    total++;
    if (st !== 2'd1) begin bad++; $display("FAIL full_state: got %0d want 1", st); end
    for (int j = 0; j < 41; j++) begin
      cycle('1);
      exp = (j >= 9) ? j - 9 : -1;
      total++;
      if (beat_n() !== exp) begin
        bad++; $display("FAIL full_drain%0d: got %0d want %0d", j, beat_n(), exp);
      end
    end
  endtask

  task automatic test_tlast();
    do_reset();
    tl_en = 16'h7FFF;
    for (int i = 0; i < 45; i++) begin
      cycle('1);
      total++;
      if (aerr !== (i >= 40)) begin
        bad++; $display("FAIL tlast_aerr%0d: got %0d want %0d", i, aerr, (i >= 40));
      end
      if (i == 40) begin
        total++;
        if ({oql, oil} !== 16'h7FFF) begin
          bad++; $display("FAIL tlast_bits: got %h want 7fff", {oql, oil});
        end
        total++;
        if (beat_n() !== 31) begin bad++; $display("FAIL tlast_data: got %0d want 31", beat_n()); end
      end
    end
    for (int i = 0; i < 15; i++) cycle('0);
    total++;
    if (aerr !== 1'b1) begin bad++; $display("FAIL tlast_sticky: got %0d want 1", aerr); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    for (int i = 0; i < 15; i++) cycle('1);
    for (int i = 0; i < 12; i++) cycle('0);
    total++;
    if (ucnt !== 16'd1) begin bad++; $display("FAIL midrst_pre_ucnt: got %0d want 1", ucnt); end
    for (int i = 0; i < 15; i++) cycle('1);
    total++;
    if (st !== 2'd2) begin bad++; $display("FAIL midrst_pre_state: got %0d want 2", st); end
    reset = 1'b1;
    iv = '1; qv = '1;
    @(negedge clk);
    reset = 1'b0;
    iv = '0; qv = '0;
    total++;
    if (beat_n() !== -1) begin bad++; $display("FAIL midrst_out: got %0d want -1", beat_n()); end
    total++;
    if (st !== 2'd0) begin bad++; $display("FAIL midrst_state: got %0d want 0", st); end
    total++;
    if ({qr, ir} !== 16'hFFFF) begin bad++; $display("FAIL midrst_ready: got %h want ffff", {qr, ir}); end
    total++;
    if (ucnt !== 16'd0) begin bad++; $display("FAIL midrst_ucnt: got %0d want 0", ucnt); end
    @(negedge clk);
    total++;
    if (st !== 2'd0) begin bad++; $display("FAIL midrst_idle: got %0d want 0", st); end
  endtask

  task automatic test_saturate();
    logic [15:0] exp;
    do_reset();
    force dut.urun_q = 16'hFFFD;
    @(negedge clk);
    release dut.urun_q;
    @(negedge clk);
    total++;
    if (ucnt !== 16'hFFFD) begin bad++; $display("FAIL sat_preload: got %h want fffd", ucnt); end
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 12; i++) cycle('1);
      for (int i = 0; i < 12; i++) cycle('0);
      exp = (r == 0) ? 16'hFFFE : 16'hFFFF;
      total++;
      if (ucnt !== exp) begin bad++; $display("FAIL sat_rep%0d: got %h want %h", r, ucnt, exp); end
    end
  endtask

  initial begin
    reset = 1'b1;
    iv = '0; qv = '0; id = '0; qd = '0; il = '0; ql = '0;
    tl_en = '0;
    for (int k = 0; k < NS; k++) n[k] = 0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_underrun();
    test_full();
    test_tlast();
    test_reset_mid_run();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
